// File: rtl/mux_sel_scanner.sv
// mux_sel_scanner: round-robin select sequencer for a 4:1 mux that packs one sample per channel into a word.
// Optional feature macro: SCAN_PARITY_EN (registers parity of each packed word on word_par).
module mux_sel_scanner #(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cont,
    input  logic       mux_out,
    output logic       s0,
    output logic       s1,
    output logic       busy,
    output logic [3:0] word,
    output logic       word_valid,
    output logic       word_par
);
    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic [7:0] LAST = 8'(DWELL - 1);

    state_t      state_q, state_d;
    logic [1:0]  ch_q, ch_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  shadow_q, shadow_d;
    logic [3:0]  word_q, word_d;
    logic        valid_q, valid_d;
    logic        dwell_end, sample_last;

    assign dwell_end   = cnt_q == LAST;
    assign sample_last = state_q == SCAN && dwell_end && ch_q == 2'd3;

    // Next-state: dwell counting, per-channel sampling and word assembly.
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        word_d   = word_q;
        valid_d  = 1'b0;
        if (state_q == IDLE) begin
            if (start) begin
                state_d = SCAN;
                ch_d    = 2'd0;
                cnt_d   = 8'd0;
            end
        end else if (!dwell_end) begin
            cnt_d = cnt_q + 8'd1;
        end else if (ch_q != 2'd3) begin
            shadow_d = {ch_q == 2'd2 ? mux_out : shadow_q[2],
                        ch_q == 2'd1 ? mux_out : shadow_q[1],
                        ch_q == 2'd0 ? mux_out : shadow_q[0]};
            ch_d     = ch_q + 2'd1;
            cnt_d    = 8'd0;
        end else begin
            word_d  = {mux_out, shadow_q};
            valid_d = 1'b1;
            ch_d    = 2'd0;
            cnt_d   = 8'd0;
            state_d = cont ? SCAN : IDLE;
        end
    end

    // State register with synchronous active-low reset; a reset mid-scan discards the partial word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ch_q     <= 2'd0;
            cnt_q    <= 8'd0;
            shadow_q <= 3'd0;
            word_q   <= 4'd0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
        end
    end

`ifdef SCAN_PARITY_EN
    logic par_q;

    // Parity is captured on the same edge as the word and holds with it.
    always_ff @(posedge clk) begin
        if (!rst_n) par_q <= 1'b0;
        else if (sample_last) par_q <= ^{mux_out, shadow_q};
    end

    assign word_par = par_q;
`else
    assign word_par = 1'b0;
`endif

    assign s0         = ch_q[0];
    assign s1         = ch_q[1];
    assign busy       = state_q == SCAN;
    assign word       = word_q;
    assign word_valid = valid_q;
endmodule
